// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, digit width
// and the digit-index width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Digit index needs ceil(log2(n)) bits, but never fewer than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// Purely combinational 4-bit carry-lookahead adder used for one digit per cycle.
module nibble_serial_adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum-of-products of g/p/cin, no ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: captures a/b/cin, adds one 4-bit digit per cycle through
// a single CLA, then holds sum/cout until the consumer takes them.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int                W        = NIBBLE_W * NIBBLES;
    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e               state_q, state_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                 carry_q, carry_d, cout_q, cout_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [NIBBLE_W-1:0]  a_dig [NIBBLES];
    logic [NIBBLE_W-1:0]  b_dig [NIBBLES];
    logic [NIBBLES-1:0]   dig_we;
    logic [NIBBLE_W-1:0]  dig_a, dig_b, dig_sum;
    logic                 dig_cout;
    logic                 accept, last_digit;
    logic                 in_ready, out_valid;

    assign accept     = (state_q == ST_IDLE) && bus.in_valid;
    assign last_digit = (idx_q == LAST_IDX);

    // Per-digit slicing of the captured operands and write-back into sum.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_digit
            assign a_dig[gi]  = a_q[gi*NIBBLE_W +: NIBBLE_W];
            assign b_dig[gi]  = b_q[gi*NIBBLE_W +: NIBBLE_W];
            assign dig_we[gi] = (state_q == ST_ADD) && (idx_q == IDX_W'(gi));
            assign sum_d[gi*NIBBLE_W +: NIBBLE_W] =
                dig_we[gi] ? dig_sum : sum_q[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign dig_a = a_dig[idx_q];
    assign dig_b = b_dig[idx_q];

    nibble_serial_adder_cla4 u_cla (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_ADD;
            ST_ADD:  if (last_digit)    state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        a_d     = accept ? bus.a : a_q;
        b_d     = accept ? bus.b : b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        if (accept) begin
            carry_d = bus.cin;
            idx_d   = '0;
        end else if (state_q == ST_ADD) begin
            carry_d = dig_cout;
            idx_d   = idx_q + 1'b1;
            if (last_digit) cout_d = dig_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against plain a+b+cin.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the expected result is plain (a + b + cin) at W+1 bits.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input int hold, input bit toggle);
        logic [W:0] full;
        full = (W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_cin);
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = op_a;
        bus.b        = op_b;
        bus.cin      = op_cin;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            check_eq("out_valid_add", 32'(bus.out_valid), 32'd0);
            check_eq("in_ready_add", 32'(bus.in_ready), 32'd0);
            if (toggle) begin
                bus.a         = W'($urandom);
                bus.b         = W'($urandom);
                bus.cin       = 1'($urandom);
                bus.in_valid  = 1'($urandom);
                bus.out_ready = 1'($urandom);
            end
            step();
        end
        bus.out_ready = 1'b0;
        check_eq("out_valid_latency", 32'(bus.out_valid), 32'd1);
        check_eq("sum", 32'(bus.sum), 32'(full[W-1:0]));
        check_eq("cout", 32'(bus.cout), 32'(full[W]));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = W'($urandom);
            step();
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_sum", 32'(bus.sum), 32'(full[W-1:0]));
            check_eq("hold_cout", 32'(bus.cout), 32'(full[W]));
        end
        // in_valid high on the leaving edge must not start a new operation.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("exit_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("exit_in_ready", 32'(bus.in_ready), 32'd1);
        $display("txn a=%h b=%h cin=%0d hold=%0d toggle=%0d -> expect sum=%h cout=%0d",
                 op_a, op_b, op_cin, hold, toggle, full[W-1:0], full[W]);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        // Reset wins over in_valid at the same edge.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_sum", 32'(bus.sum), 32'd0);
        check_eq("rst_cout", 32'(bus.cout), 32'd0);

        run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 3, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1, 1'b1);

        // Reset on the second ADD edge discards the operation.
        bus.in_valid = 1'b1;
        bus.a        = 16'h8765;
        bus.b        = 16'h4321;
        bus.cin      = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_sum", 32'(bus.sum), 32'd0);
        check_eq("midrst_cout", 32'(bus.cout), 32'd0);
        for (int k = 0; k < 2 * NIBBLES; k++) begin
            step();
            check_eq("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        $display("txn reset during ADD -> expect operation discarded");

        for (int t = 0; t < 24; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
- Parameters (name, default, meaning):
  - REQ-001: NIBBLES, 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES.
- Ports (name, direction, width, meaning):
  - REQ-002: clk, in, 1, single clock; all state changes on rising edge.
  - REQ-003: rst, in, 1, reset; synchronous, active-high.
  - REQ-004: in_valid, in, 1, operand set a/b/cin present.
  - REQ-005: in_ready, out, 1, block can accept operands.
  - REQ-006: a, in, W, operand A.
  - REQ-007: b, in, W, operand B.
  - REQ-008: cin, in, 1, carry-in to digit 0.
  - REQ-009: out_valid, out, 1, sum/cout valid.
  - REQ-010: out_ready, in, 1, consumer accepts result.
  - REQ-011: sum, out, W, registered result.
  - REQ-012: cout, out, 1, registered carry-out of the top digit.

Function
- REQ-013: The block SHALL use states IDLE, ADD and DONE.
- REQ-014: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
- REQ-015: Accept occurs at an edge where state=IDLE and in_valid=1. At accept, a, b and cin SHALL be captured, the digit index SHALL be cleared to 0, and the state SHALL go to ADD.
- REQ-016: Each ADD edge SHALL add digit i of A, digit i of B and the carry register through one 4-bit CLA.
  - The 4-bit sum SHALL be written to sum[4i+3:4i].
  - The CLA carry-out SHALL be written to the carry register.
  - The digit index SHALL then increment.
- REQ-017: The ADD edge that processes digit NIBBLES-1 SHALL also load cout and set state to DONE.
- REQ-018: Latency SHALL be fixed. If accept occurs at edge N, out_valid SHALL be 1 from edge N+NIBBLES onward.
- REQ-019: In DONE, sum and cout SHALL hold stable until an edge with out_ready=1; at that edge the state SHALL go to IDLE.
- REQ-020: A new accept SHALL NOT occur in the edge that leaves DONE. The minimum spacing between accepts SHALL be NIBBLES+2 edges.
- REQ-021: Inputs a, b and cin SHALL be ignored outside the accept edge. Changing them during ADD SHALL NOT affect the result.
- REQ-022: The result SHALL equal (a + b + cin) mod 2^W, with cout = bit W of the full sum.
- REQ-023: Wrap-around cases SHALL be exact: all-ones + 1 and all-ones + all-ones + 1 SHALL produce the correct sum and carry.
- REQ-024: While in DONE, sum and cout SHALL be unaffected by in_valid; partial sum bits SHALL be visible during ADD but out_valid=0 then.

Reset
- REQ-025: When rst=1 at an edge, the block SHALL enter IDLE and set sum=0, cout=0, carry=0, index=0, out_valid=0 and in_ready=1 (effective after that edge), regardless of state.
- REQ-026: Reset during ADD or DONE SHALL discard the operation; no out_valid pulse SHALL follow.
- REQ-027: rst SHALL take priority over in_valid and out_ready at the same edge.

Structure
- REQ-028: A shared package SHALL hold the state encoding (IDLE=0, ADD=1, DONE=2, 2 bits) and the constant NIBBLE_W=4.
- REQ-029: The digit adder SHALL be one instance of the team's existing 4-bit CLA module (ports a, b, cin, sum, cout), used combinationally.
- REQ-030: The digit index SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1 bit.

Verification (NIBBLES=4)
- REQ-031: 0x0000 + 0x0000, cin=0 -> after 4 edges sum=0x0000, cout=0, out_valid=1.
- REQ-032: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all digits).
- REQ-033: 0xA5A5 + 0x5A5A, cin=1 -> sum=0x0000, cout=1; then 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0; accepts are NIBBLES+2 edges apart.
- REQ-034: Result 0xFFFF + 0xFFFF, cin=1, held with out_ready=0 for 3 cycles -> sum=0xFFFF and cout=1 stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
- REQ-035: rst=1 on the 2nd ADD edge -> next cycle in_ready=1, out_valid=0, sum=0x0000, cout=0, and no later out_valid.
- REQ-036: a and b toggled randomly during ADD -> result matches the operands captured at accept.
